// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, line levels
// and the bit-period divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 8N1 line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping, reported as one-hot plus index.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int            w_cand;
    logic [IW-1:0] w_cidx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        w_cidx  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            w_cidx = IW'(w_cand);
            if (!o_valid && i_req[w_cidx]) begin
                o_valid         = 1'b1;
                o_idx           = w_cidx;
                o_grant[w_cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one 8N1 UART transmit line between N_REQ clients using round-robin
// arbitration; owns all TX bit timing. dbg_state mirrors the FSM state.
module uart_tx_sched #(
    parameter int CLK    = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  data_in,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     tx,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [1:0]               dbg_state
);
    import uart_pkg::*;

    localparam int DIVISOR = calc_divisor(CLK, BAUD);
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int BIDX_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(DIVISOR - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT   = BIDX_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(N_REQ - 1);

    if (DIVISOR < 16) begin : g_div_check
        $error("uart_tx_sched: CLK/BAUD must be at least 16");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_check
        $error("uart_tx_sched: N_REQ must be in 2..8");
    end
    if (DATA_W < 2) begin : g_dw_check
        $error("uart_tx_sched: DATA_W must be at least 2");
    end

    tx_state_e          r_state;
    logic [ID_W-1:0]    r_rr;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [BIDX_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]  r_shift;
    logic [ID_W-1:0]    r_owner;
    logic [N_REQ-1:0]   r_grant;
    logic               r_busy;
    logic               r_tx;
    logic               r_done;
    logic [ID_W-1:0]    r_done_id;

    logic [N_REQ-1:0]   w_win_grant;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_win_valid;
    logic [DATA_W-1:0]  w_win_byte;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (req),
        .i_ptr   (r_rr),
        .o_grant (w_win_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    assign w_win_byte = data_in[w_win_idx*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_tx      <= LINE_IDLE;
            r_done    <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_grant   <= w_win_grant;
                        r_shift   <= w_win_byte;
                        r_owner   <= w_win_idx;
                        r_rr      <= (w_win_idx == LAST_ID) ? '0 : w_win_idx + 1'b1;
                        r_tx      <= START_BIT;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= CNT_RELOAD;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (r_bit_cnt == '0) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_bit_cnt <= CNT_RELOAD;
                        r_state   <= DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (r_bit_cnt == '0) begin
                        r_bit_cnt <= CNT_RELOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
                        end else begin
                            // shift[1] is the bit that lands in shift[0] after this shift
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (r_bit_cnt == '0) begin
                        r_done    <= 1'b1;
                        r_done_id <= r_owner;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = r_busy;
    assign tx        = r_tx;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched with DIVISOR=16: directed client requests feed an
// expected-frame queue that a negedge monitor consumes on every grant.
module tb_uart_tx_sched;

    localparam int DIV = 16;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int IDW = 2;
    localparam int EW  = 1 + IDW + 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] data_in = '0;
    logic [NR-1:0]  grant;
    logic           busy;
    logic           tx;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .CLK    (DIV),
        .BAUD   (1),
        .N_REQ  (NR),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .busy      (busy),
        .tx        (tx),
        .done      (done),
        .done_id   (done_id),
        .dbg_state (dbg_state)
    );

    int tests = 0;
    int fails = 0;

    // entry: {back_to_back, client id, 10-bit frame with bit0 = start bit}
    logic [EW-1:0] exp_q[$];

    int            cyc = 0;
    bit            mon_active = 1'b0;
    int            mon_c = 0;
    logic [EW-1:0] cur = '0;
    int            err_tx = 0;
    int            err_busy = 0;
    int            err_done = 0;
    int            last_done_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [EW-1:0] mk(input bit b2b, input int id, input logic [9:0] frame);
        logic [IDW-1:0] idv;
        idv = IDW'(id);
        return {b2b, idv, frame};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (grant != '0) begin
                if (mon_active) begin
                    check("grant_in_frame", 32'(grant), 32'd0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_id", 32'(grant), 32'd1 << cur[11:10]);
                    if (cur[12]) check("b2b_gap", cyc, last_done_cyc + 1);
                    mon_active = 1'b1;
                    mon_c = 0;
                    err_tx = 0;
                    err_busy = 0;
                    err_done = 0;
                end
            end
            if (mon_active) begin
                if (mon_c < 10 * DIV) begin
                    if (tx !== cur[mon_c / DIV]) err_tx++;
                    if (busy !== 1'b1) err_busy++;
                    if (done !== 1'b0) err_done++;
                    mon_c++;
                end else begin
                    check("frame_tx_errs", err_tx, 0);
                    check("frame_busy_errs", err_busy, 0);
                    check("early_done", err_done, 0);
                    check("done_at_160", 32'(done), 32'd1);
                    check("done_id", 32'(done_id), 32'(cur[11:10]));
                    check("tx_after_frame", 32'(tx), 32'd1);
                    check("busy_after_frame", 32'(busy), 32'd0);
                    mon_active = 1'b0;
                    last_done_cyc = cyc;
                end
            end else if (done) begin
                check("unexpected_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input int id);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (grant[id]) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_grant%0d: no grant within 400 cycles", id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !mon_active) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: %0d frames still pending after 3000 cycles", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int cnt_a;
        int cnt_b;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_done_id", 32'(done_id), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single byte from client 2
        data_in[23:16] = 8'hA5;
        exp_q.push_back(mk(0, 2, 10'b1_10100101_0));
        req = 4'b0100;
        wait_grant(2);
        req = '0;
        wait_idle();

        // Pointer now at 3: 0b1001 serves 3, then 0 back-to-back
        data_in[31:24] = 8'h3C;
        data_in[7:0]   = 8'h81;
        exp_q.push_back(mk(0, 3, 10'b1_00111100_0));
        exp_q.push_back(mk(1, 0, 10'b1_10000001_0));
        req = 4'b1001;
        wait_grant(3);
        req = 4'b0001;
        wait_grant(0);
        req = '0;
        wait_idle();

        // Reset during data bit 4 of 0x00 (client 1)
        data_in[15:8] = 8'h00;
        exp_q.push_back(mk(0, 1, 10'b1_00000000_0));
        req = 4'b0010;
        wait_grant(1);
        req = '0;
        tick(85);
        check("bit4_level", 32'(tx), 32'd0);
        check("bit4_state", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        tick(1);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        tick(1);
        rst_n = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (done) cnt_a++;
            if (!tx) cnt_b++;
        end
        check("abort_no_done", cnt_a, 0);
        check("abort_tx_idle", cnt_b, 0);

        // Fairness with all clients requesting
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        exp_q.push_back(mk(0, 0, 10'b1_00010001_0));
        exp_q.push_back(mk(1, 1, 10'b1_00100010_0));
        exp_q.push_back(mk(1, 2, 10'b1_00110011_0));
        exp_q.push_back(mk(1, 3, 10'b1_01000100_0));
        exp_q.push_back(mk(1, 0, 10'b1_00010001_0));
        req = 4'b1111;
        wait_grant(0);
        wait_grant(1);
        wait_grant(2);
        wait_grant(3);
        wait_grant(0);
        req = '0;
        wait_idle();

        // Late request from client 0 while client 3 is in DATA
        exp_q.push_back(mk(0, 3, 10'b1_01000100_0));
        req = 4'b1000;
        wait_grant(3);
        req = '0;
        tick(40);
        check("late_in_data", 32'(dbg_state), 32'd2);
        exp_q.push_back(mk(1, 0, 10'b1_00010001_0));
        req = 4'b0001;
        wait_grant(0);
        req = '0;

        // Withdrawn request: one-cycle pulse from client 1 while busy
        tick(30);
        req = 4'b0010;
        tick(1);
        req = '0;
        wait_idle();
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (grant != '0) cnt_a++;
            if (!tx) cnt_b++;
        end
        check("withdrawn_no_grant", cnt_a, 0);
        check("withdrawn_tx_idle", cnt_b, 0);
        check("withdrawn_busy", 32'(busy), 32'd0);
        check("withdrawn_state", 32'(dbg_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
